// File: rtl/tb_sched_pkg.sv
// Shared types and constants for the bench command scheduler.
package tb_sched_pkg;

    localparam int unsigned ARG_CHARS    = 16;
    localparam int unsigned ARG_W        = 8 * ARG_CHARS;
    localparam int unsigned CMD_TARGET_W = 32;
    localparam int unsigned WDOG_DEFAULT = 100000;

    // One command argument: ASCII text, right-justified, zero padded ("" == 0).
    typedef logic [ARG_W-1:0] arg_t;

    typedef enum logic [2:0] {
        IDLE,
        DISPATCH,
        WAIT,
        COMPLETE,
        ABORT
    } sched_state_t;

endpackage

// File: rtl/tb_cmd_fifo.sv
// Command queue: power-of-two depth, registered ready/empty flags.
module tb_cmd_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data_c,
    output logic              ready,
    output logic              empty,
    output logic              empty_next_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_d;
    logic              do_push;
    logic              do_pop;

    assign do_push   = push & ready;
    assign do_pop    = pop & ~empty;
    assign rd_data_c = mem[rd_ptr];

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_d = count;
        case ({do_push, do_pop})
            2'b10:   count_d = count + CNT_W'(1);
            2'b01:   count_d = count - CNT_W'(1);
            default: count_d = count;
        endcase
        empty_next_c = (count_d == CNT_W'(0));
    end

    // Pointers, count and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b1;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_d;
            ready <= (count_d != CNT_W'(DEPTH));
            empty <= empty_next_c;
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/tb_cmd_scheduler.sv
// Queues bench commands and dispatches them one at a time to per-function bench modules.
module tb_cmd_scheduler
    import tb_sched_pkg::*;
#(
    parameter int unsigned ARGS_NB     = 5,
    parameter int unsigned TARGET_NB   = 4,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned WDOG_CYCLES = WDOG_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic [CMD_TARGET_W-1:0] i_cmd_target,
    input  arg_t [ARGS_NB-1:0]      i_cmd_args,
    output logic [TARGET_NB-1:0]    o_sel,
    output logic                    o_args_valid,
    output arg_t [ARGS_NB-1:0]      o_args,
    input  logic [TARGET_NB-1:0]    i_done,
    output logic                    o_busy,
    output logic [31:0]             o_cmd_cnt,
    output logic                    o_err_timeout,
    output logic                    o_err_target
);

    localparam int unsigned TGT_W  = (TARGET_NB > 1) ? $clog2(TARGET_NB) : 1;
    localparam int unsigned WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

    typedef struct packed {
        logic [CMD_TARGET_W-1:0] target;
        arg_t [ARGS_NB-1:0]      args;
    } cmd_t;

    sched_state_t        state_q, state_d;
    logic [TGT_W-1:0]    tgt_q, tgt_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic [TARGET_NB-1:0] sel_d;
    logic                args_valid_d;
    arg_t [ARGS_NB-1:0]  args_d;
    logic [31:0]         cnt_d;
    logic                err_timeout_d;
    logic                err_target_d;
    logic                busy_d;

    logic                fifo_pop;
    logic                fifo_ready;
    logic                fifo_empty;
    logic                fifo_empty_next_c;
    cmd_t                push_cmd;
    cmd_t                head;

    assign push_cmd    = '{target: i_cmd_target, args: i_cmd_args};
    assign o_cmd_ready = fifo_ready;

    tb_cmd_fifo #(
        .DATA_W ($bits(cmd_t)),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (i_cmd_valid),
        .wr_data      (push_cmd),
        .pop          (fifo_pop),
        .rd_data_c    (head),
        .ready        (fifo_ready),
        .empty        (fifo_empty),
        .empty_next_c (fifo_empty_next_c)
    );

    // Next state and next registered outputs; outputs are computed for the state being entered.
    always_comb begin
        state_d       = state_q;
        tgt_d         = tgt_q;
        wdog_d        = wdog_q;
        sel_d         = o_sel;
        args_valid_d  = 1'b0;
        args_d        = o_args;
        cnt_d         = o_cmd_cnt;
        err_timeout_d = 1'b0;
        err_target_d  = 1'b0;
        fifo_pop      = 1'b0;

        case (state_q)
            IDLE: begin
                sel_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    args_d   = head.args;
                    if (head.target >= CMD_TARGET_W'(TARGET_NB)) begin
                        err_target_d = 1'b1;
                    end else begin
                        tgt_d        = TGT_W'(head.target);
                        sel_d[tgt_d] = 1'b1;
                        args_valid_d = 1'b1;
                        state_d      = DISPATCH;
                    end
                end
            end
            DISPATCH: begin
                wdog_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Done from the selected target wins over watchdog expiry.
                if (i_done[tgt_q]) begin
                    sel_d   = '0;
                    cnt_d   = o_cmd_cnt + 32'd1;
                    state_d = COMPLETE;
                end else if (wdog_q == WDOG_W'(WDOG_CYCLES - 1)) begin
                    sel_d         = '0;
                    err_timeout_d = 1'b1;
                    state_d       = ABORT;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            COMPLETE: begin
                sel_d   = '0;
                state_d = IDLE;
            end
            ABORT: begin
                sel_d   = '0;
                state_d = IDLE;
            end
            default: begin
                sel_d   = '0;
                state_d = IDLE;
            end
        endcase

        busy_d = !fifo_empty_next_c || (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            tgt_q         <= '0;
            wdog_q        <= '0;
            o_sel         <= '0;
            o_args_valid  <= 1'b0;
            o_args        <= '0;
            o_cmd_cnt     <= '0;
            o_err_timeout <= 1'b0;
            o_err_target  <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            state_q       <= state_d;
            tgt_q         <= tgt_d;
            wdog_q        <= wdog_d;
            o_sel         <= sel_d;
            o_args_valid  <= args_valid_d;
            o_args        <= args_d;
            o_cmd_cnt     <= cnt_d;
            o_err_timeout <= err_timeout_d;
            o_err_target  <= err_target_d;
            o_busy        <= busy_d;
        end
    end

endmodule
